tqvp_pwm_audio: RTL and testbench
=================================

# tqvp_pwm_audio

Sample-streaming audio output peripheral on the TinyQV peripheral bus. The CPU pushes 8-bit unsigned samples into a small FIFO. A programmable sample-rate divider pops one sample per period, and a fixed 256-clock PWM modulator drives the sample onto `uo_out[7]` for an external RC filter. A low-watermark interrupt requests refills, so this block is the downstream audio sink for sample data the CPU or other peripherals produce.

## Interface
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, 2..16.
- `clk` in 1: project clock (64 MHz nominal).
- `rst_n` in 1: reset, synchronous, active-low; one clock domain.
- `ui_in` in 8: input PMOD; unused.
- `uo_out` out 8: bit 7 = PWM audio, bit 6 = sample-tick strobe, bits 5:0 = 0.
- `address` in 6: register address.
- `data_in` in 32: write data.
- `data_write_n` in 2: 11 = none, 00/01/10 = 8/16/32-bit write.
- `data_read_n` in 2: 11 = none, else read.
- `data_out` out 32: read data.
- `data_ready` out 1: constant 1.
- `user_interrupt` out 1: low-watermark interrupt, level.

## Operation
- **Registers.** A write is any `data_write_n != 11`. Unlisted addresses read 0 and ignore writes.
  - 0x00 DATA (W): push `data_in[7:0]`. Reads 0.
  - 0x04 CTRL (R/W): [0] EN, [1] IE, [2] FLUSH (self-clearing, reads 0), [7:4] LOWAT.
  - 0x08 DIV (R/W, 16-bit): sample period is DIV+1 clocks. Writes with width ≥16 bits load [15:0]; 8-bit writes load [7:0] only.
  - 0x0C STATUS (R): [4:0] level, [5] EMPTY, [6] FULL, [7] UNF (sticky), [8] OVF (sticky). Writing 1 to bit 7 or bit 8 clears that flag.
- **FIFO.**
  - Circular buffer with `FIFO_DEPTH` entries; the level counter is 5 bits.
  - A push when full and with no same-cycle pop is dropped and sets OVF.
  - A push and a pop in the same cycle: the pop takes the current head, and the push is accepted even when the FIFO is full. The level is unchanged.
  - FLUSH sets the level to 0 and resets both pointers. UNF and OVF are not cleared.
- **Sample divider.**
  - While EN=1, a 16-bit counter counts 0..DIV and asserts `tick` for one cycle when count == DIV, then wraps to 0.
  - On `tick` with level > 0: pop into `next_sample`.
  - On `tick` with the FIFO empty: `next_sample` holds its value and UNF is set.
  - A simultaneous push into an empty FIFO is still accepted; it is not popped that cycle.
- **PWM.**
  - An 8-bit `pwm_cnt` increments every clock while EN=1.
  - When `pwm_cnt` == 255 (the wrap), `cur_sample` <= `next_sample`. Duty changes only at period boundaries.
  - `uo_out[7]` = EN & (`pwm_cnt` < `cur_sample`), registered. Sample 0 is always low; 255 is high 255/256.
  - `uo_out[6]` = `tick`, delayed one cycle.
- **Disable.** EN=0 clears the divider counter, `pwm_cnt`, `cur_sample`, `next_sample` and both `uo_out` bits. FIFO contents and flags are retained, so the CPU can pre-fill the FIFO before enabling.
- **Interrupt.** `user_interrupt` = EN & IE & (level ≤ LOWAT), registered. It deasserts when the level rises above LOWAT or when IE or EN is cleared.

## Timing
- **Reset** (rst_n low at a clock edge) sets all state to 0:
  - CTRL=0, DIV=0, level=0, UNF=OVF=0.
  - `uo_out`=0 and `user_interrupt`=0.
  - `data_out` reflects the reset register values; `data_ready`=1.
- **Reset mid-stream** discards the FIFO. The next cycle is identical to the post-reset state.
- **Reads** are combinational from current register state, with 0-cycle latency.
- **Register write latency.**
  - Register writes take effect at the next edge.
  - A STATUS read in the cycle after a DATA write shows the new level.
- **Pop and duty latency.**
  - Pop latency: `tick` cycle E, `next_sample` is valid at E+1.
  - The new sample reaches the PWM duty at the first `pwm_cnt` wrap after that.
- **Divider timing.**
  - DIV=0 gives `tick` every cycle.
  - A DIV write takes effect immediately. If the counter already exceeds the new DIV, it counts on through 65535 and wraps before ticking.
- **Simultaneous events.**
  - A STATUS write-1-to-clear in the same cycle as a new UNF/OVF event: the set wins.
  - FLUSH in the same cycle as a push: the FLUSH wins and the push is dropped; OVF is not set.

## Test plan
- **Reset:** rst_n low 2 cycles → `uo_out`=0x00, `user_interrupt`=0, STATUS reads 0x020 (EMPTY).
- **Fill/overflow:** with EN=0, push 9 samples → STATUS level=8, FULL=1, OVF=1. Write 0x100 to STATUS → OVF=0.
- **Playback duty:** DIV=1023, push 0x40 then 0xC0, EN=1 → after the first tick, PWM high exactly 64 of 256 clocks per period. After the second tick, 192 of 256. The strobe on `uo_out[6]` occurs every 1024 clocks.
- **Underrun:** EN=1 with the FIFO empty and DIV=15 → at the first tick UNF=1 and `uo_out[7]` stays 0. Pushing 0x80 → it is popped at the next tick.
- **Interrupt:** LOWAT=2, IE=1, EN=1, 4 samples queued → `user_interrupt`=0. It rises the cycle after the level drops to 2, and falls after one push.
- **Corner:** push while full in the same cycle as a tick → level stays 8, OVF stays 0. Then FLUSH together with a push → level 0, OVF stays 0.

Source files
------------

// File: rtl/tqvp_pwm_audio.sv
// Sample-streaming PWM audio sink for the TinyQV peripheral bus.
// CPU fills an 8-bit sample FIFO; a rate divider pops samples into a 256-clock PWM.
module tqvp_pwm_audio #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]     LVL_FULL = 5'(FIFO_DEPTH);

  localparam logic [5:0] A_DATA = 6'h00;
  localparam logic [5:0] A_CTRL = 6'h04;
  localparam logic [5:0] A_DIV  = 6'h08;
  localparam logic [5:0] A_STAT = 6'h0C;

  typedef struct packed {
    logic        wr;
    logic        wide;
    logic [5:0]  addr;
    logic [15:0] data;
  } bus_req_t;

  bus_req_t w_req;
  assign w_req.wr   = (data_write_n != 2'b11);
  assign w_req.wide = (data_write_n != 2'b00);
  assign w_req.addr = address;
  assign w_req.data = data_in[15:0];

  // control / status state
  logic          r_en, r_ie, r_unf, r_ovf;
  logic [3:0]    r_lowat;
  logic [15:0]   r_div;
  logic [AW-1:0] r_wp, r_rp;
  logic [4:0]    r_level;
  logic [7:0]    r_mem [FIFO_DEPTH];

  // playback datapath state
  logic [15:0]   r_divcnt;
  logic [7:0]    r_pwm_cnt, r_cur, r_next;
  logic          r_pwm_out, r_tick_d, r_irq;

  logic w_wr_data, w_wr_ctrl, w_wr_div, w_wr_stat;
  logic w_flush, w_full, w_empty, w_tick, w_pop, w_push_ok, w_ovf_set, w_unf_set;
  logic [4:0] w_level_nxt;

  assign w_wr_data = w_req.wr & (w_req.addr == A_DATA);
  assign w_wr_ctrl = w_req.wr & (w_req.addr == A_CTRL);
  assign w_wr_div  = w_req.wr & (w_req.addr == A_DIV);
  assign w_wr_stat = w_req.wr & (w_req.addr == A_STAT);
  assign w_flush   = w_wr_ctrl & w_req.data[2];

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == 5'd0);
  assign w_tick    = r_en & (r_divcnt == r_div);
  assign w_pop     = w_tick & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_wr_data & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_wr_data & ~w_flush & w_full & ~w_pop;
  assign w_unf_set = w_tick & w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop})
      2'b10:   w_level_nxt = r_level + 5'd1;
      2'b01:   w_level_nxt = r_level - 5'd1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_lowat <= 4'd0;
      r_div   <= 16'd0;
      r_unf   <= 1'b0;
      r_ovf   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= 5'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= w_req.data[0];
        r_ie    <= w_req.data[1];
        r_lowat <= w_req.data[7:4];
      end
      if (w_wr_div) begin
        if (w_req.wide) r_div <= w_req.data;
        else            r_div[7:0] <= w_req.data[7:0];
      end
      // New events outrank a same-cycle write-1-to-clear.
      if (w_unf_set)                      r_unf <= 1'b1;
      else if (w_wr_stat & w_req.data[7]) r_unf <= 1'b0;
      if (w_ovf_set)                                   r_ovf <= 1'b1;
      else if (w_wr_stat & w_req.wide & w_req.data[8]) r_ovf <= 1'b0;
      if (w_flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_level <= 5'd0;
      end else begin
        if (w_push_ok) r_wp <= r_wp + AW'(1);
        if (w_pop)     r_rp <= r_rp + AW'(1);
        r_level <= w_level_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= w_req.data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !r_en) begin
      r_divcnt  <= 16'd0;
      r_pwm_cnt <= 8'd0;
      r_cur     <= 8'd0;
      r_next    <= 8'd0;
      r_pwm_out <= 1'b0;
      r_tick_d  <= 1'b0;
    end else begin
      // Counter past a freshly lowered DIV simply runs on to 65535 and wraps.
      r_divcnt  <= w_tick ? 16'd0 : r_divcnt + 16'd1;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (w_pop)              r_next <= r_mem[r_rp];
      if (r_pwm_cnt == 8'hFF) r_cur  <= r_next;
      r_pwm_out <= (r_pwm_cnt < r_cur);
      r_tick_d  <= w_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_en & r_ie & (r_level <= {1'b0, r_lowat});
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      A_CTRL:  data_out = {24'd0, r_lowat, 2'b00, r_ie, r_en};
      A_DIV:   data_out = {16'd0, r_div};
      A_STAT:  data_out = {23'd0, r_ovf, r_unf, w_full, w_empty, r_level};
      default: data_out = 32'd0;
    endcase
  end

  assign uo_out         = {r_pwm_out, r_tick_d, 6'd0};
  assign data_ready     = 1'b1;
  assign user_interrupt = r_irq;

  logic w_unused;
  assign w_unused = &{1'b0, ui_in, data_read_n, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_pwm_audio.sv
// Directed + randomized bench for tqvp_pwm_audio; FIFO/flags modelled with a queue,
// duty checked by counting high clocks per 256-clock window.
module tb_tqvp_pwm_audio;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in, uo_out;
  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;

  tqvp_pwm_audio #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q[$];
  logic m_unf = 1'b0;
  logic m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int l = q.size();
    return 32'(l) + (l == 0 ? 32'h20 : 32'h0) + (l == 8 ? 32'h40 : 32'h0)
         + (m_unf ? 32'h80 : 32'h0) + (m_ovf ? 32'h100 : 32'h0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address = a; data_in = d; data_write_n = w;
    cyc();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a; data_read_n = 2'b00;
    #1;
    d = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic push(input logic [7:0] s);
    wr(6'h00, {24'd0, s}, 2'b00);
  endtask

  task automatic quiesce();
    wr(6'h04, 32'h4, 2'b10);
    wr(6'h0C, 32'h180, 2'b10);
    q.delete(); m_unf = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic wait_strobe(input int lim, output int k, output int hi);
    k = 0; hi = 0;
    do begin
      cyc(); k++; hi += int'(uo_out[7]);
    end while (!uo_out[6] && k < lim);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin cyc(); hi += int'(uo_out[7]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  s;
    int k, hi, n, found;

    rst_n = 1'b0; ui_in = 8'd0; address = 6'd0; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_uo_out", {24'd0, uo_out}, 32'h0);
    chk("rst_irq", {31'd0, user_interrupt}, 32'h0);
    chk("rst_ready", {31'd0, data_ready}, 32'h1);
    rd(6'h0C, st); chk("rst_status", st, 32'h020);
    rd(6'h04, st); chk("rst_ctrl", st, 32'h0);
    rd(6'h08, st); chk("rst_div", st, 32'h0);

    // fill past full with EN=0
    for (int i = 0; i < 9; i++) begin
      s = 8'($urandom);
      push(s);
      if (q.size() < 8) q.push_back(s); else m_ovf = 1'b1;
      if (i == 0) begin rd(6'h0C, st); chk("level_after_push", st, exp_status()); end
    end
    rd(6'h0C, st); chk("fill_ovf", st, 32'h148);
    wr(6'h04, 32'h4, 2'b10); q.delete();
    rd(6'h0C, st); chk("flush_keeps_ovf", st, 32'h120);
    wr(6'h0C, 32'h100, 2'b10); m_ovf = 1'b0;
    rd(6'h0C, st); chk("ovf_clear", st, 32'h020);

    // reset mid-stream discards FIFO
    push(8'h11); push(8'h22); push(8'h33);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    rd(6'h0C, st); chk("midreset_status", st, 32'h020);

    // register access widths and unmapped space
    wr(6'h08, 32'h0000FFFF, 2'b10);
    wr(6'h08, 32'h12345612, 2'b00);
    rd(6'h08, st); chk("div_byte_write", st, 32'hFF12);
    wr(6'h08, 32'h0000ABCD, 2'b01);
    rd(6'h08, st); chk("div_half_write", st, 32'hABCD);
    wr(6'h04, 32'hF6, 2'b00);
    rd(6'h04, st); chk("ctrl_readback", st, 32'hF2);
    wr(6'h10, 32'hFFFFFFFF, 2'b10);
    rd(6'h10, st); chk("unmapped_read", st, 32'h0);
    rd(6'h00, st); chk("data_reads_zero", st, 32'h0);

    // randomized register traffic with EN=0
    quiesce();
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 3);
      if (op <= 1) begin
        s = 8'($urandom);
        wr(6'h00, {24'($urandom), s}, 2'($urandom_range(0, 2)));
        if (q.size() < 8) q.push_back(s); else m_ovf = 1'b1;
      end else if (op == 2) begin
        int c = $urandom_range(0, 3);
        wr(6'h0C, ((c & 2) != 0 ? 32'h100 : 32'h0) | ((c & 1) != 0 ? 32'h80 : 32'h0), 2'b10);
        if ((c & 1) != 0) m_unf = 1'b0;
        if ((c & 2) != 0) m_ovf = 1'b0;
      end else begin
        wr(6'h04, 32'h4, 2'b10); q.delete();
      end
      rd(6'h0C, st); chk("rand_status", st, exp_status());
    end

    // playback duty 0x40 then 0xC0
    quiesce();
    wr(6'h08, 32'd1023, 2'b10);
    push(8'h40); push(8'hC0);
    wr(6'h04, 32'h1, 2'b10);
    wait_strobe(1100, k, hi);
    chk("strobe1_at", k, 1024);
    chk("pre_tick_low", hi, 0);
    count_high(300, hi); count_high(256, hi); chk("duty_64", hi, 64);
    wait_strobe(1100, k, hi); chk("strobe_period2", 556 + k, 1024);
    count_high(300, hi); count_high(256, hi); chk("duty_192", hi, 192);
    wait_strobe(1100, k, hi); chk("strobe_period3", 556 + k, 1024);
    rd(6'h0C, st); chk("unf_after_drain", st, 32'h0A0);
    count_high(300, hi); count_high(256, hi); chk("duty_hold", hi, 192);

    // underrun then refill
    quiesce();
    wr(6'h08, 32'd15, 2'b10);
    wr(6'h04, 32'h1, 2'b10);
    wait_strobe(100, k, hi);
    chk("unf_tick_at", k, 16);
    chk("unf_pwm_low", hi, 0);
    rd(6'h0C, st); chk("unf_set", st, 32'h0A0);
    push(8'h80);
    rd(6'h0C, st); chk("unf_refill_level", st, 32'h081);
    wait_strobe(100, k, hi); chk("unf_next_tick", k, 15);
    rd(6'h0C, st); chk("unf_popped", st, 32'h0A0);
    count_high(300, hi); count_high(256, hi); chk("duty_128", hi, 128);

    // DIV=0 ticks every cycle
    quiesce();
    wr(6'h08, 32'd0, 2'b10);
    wr(6'h04, 32'h1, 2'b10);
    cyc(); chk("div0_strobe_a", {31'd0, uo_out[6]}, 32'h1);
    cyc(); chk("div0_strobe_b", {31'd0, uo_out[6]}, 32'h1);

    // low-watermark interrupt
    quiesce();
    repeat (4) push(8'($urandom));
    wr(6'h08, 32'd63, 2'b10);
    wr(6'h04, 32'h23, 2'b10);
    cyc(); chk("irq_low_above", {31'd0, user_interrupt}, 32'h0);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      cyc(); rd(6'h0C, st);
      if (st[4:0] == 5'd2) found = 1;
    end
    chk("irq_level_reached", found, 1);
    chk("irq_not_yet", {31'd0, user_interrupt}, 32'h0);
    cyc(); chk("irq_rise", {31'd0, user_interrupt}, 32'h1);
    push(8'h10);
    cyc(); chk("irq_fall", {31'd0, user_interrupt}, 32'h0);

    // push into full FIFO coincident with tick
    quiesce();
    wr(6'h08, 32'd7, 2'b10);
    repeat (8) push(8'($urandom));
    rd(6'h0C, st); chk("corner_full", st, 32'h048);
    wr(6'h04, 32'h1, 2'b10);
    repeat (7) cyc();
    push(8'h5A);
    chk("corner_tick", {31'd0, uo_out[6]}, 32'h1);
    rd(6'h0C, st); chk("corner_level8", st, 32'h048);
    wr(6'h04, 32'h5, 2'b10);
    rd(6'h0C, st); chk("corner_flush", st, 32'h020);

    // random sample order through playback
    quiesce();
    wr(6'h08, 32'd1023, 2'b10);
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) begin
      s = 8'($urandom);
      push(s); q.push_back(s);
    end
    wr(6'h04, 32'h1, 2'b10);
    wait_strobe(1100, k, hi); chk("rplay_first", k, 1024);
    for (int i = 0; i < n; i++) begin
      count_high(300, hi); count_high(256, hi);
      chk("rplay_duty", hi, {24'd0, q.pop_front()});
      wait_strobe(1100, k, hi); chk("rplay_period", 556 + k, 1024);
    end
    m_unf = 1'b1;
    rd(6'h0C, st); chk("rplay_drained", st, exp_status());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
